// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : gray_pkg
//  Purpose   : Shared Gray-code helpers for the FIFO pointer logic.
//              bin2gray : b ^ (b >> 1)
//              gray2bin : XOR-prefix from the MSB down
//              Both work on a GRAY_MAX_W-bit container. Callers zero-extend
//              narrower values and keep the low bits of the result. Leading
//              zeros leave both transforms unchanged, so this is exact.
//  Revision  : 1.0  initial release
// ============================================================================
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_counter_core.sv
`default_nettype none
// ============================================================================
//  Module    : gray_counter_core
//  Purpose   : Binary incrementer plus a binary register and a Gray register.
//              The Gray register is loaded with the Gray code of the *next*
//              binary value. Because the Gray value is the flop output and is
//              not decoded from r_bin afterwards, only one bit changes per step.
//  Ports     : clk    in  1  counting clock (rising edge)
//              rst    in  1  synchronous active-high clear
//              o_gray out W  registered Gray count
//  Revision  : 1.0  initial release
// ============================================================================
module gray_counter_core
  import gray_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] o_gray
);

  logic [W-1:0]          r_bin;
  logic [W-1:0]          r_gray;
  logic [W-1:0]          w_bin_nxt;
  logic [GRAY_MAX_W-1:0] w_bin_ext;
  logic [GRAY_MAX_W-1:0] w_gray_ext;

  // Modulo 2**W wrap comes for free from the W-bit add.
  assign w_bin_nxt = r_bin + {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    w_bin_ext           = '0;
    w_bin_ext[W-1:0]    = w_bin_nxt;
    w_gray_ext          = bin2gray(w_bin_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_ext[W-1:0];
    end
  end

  assign o_gray = r_gray;

endmodule : gray_counter_core
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module    : gray_counter
//  Purpose   : Free-running W-bit Gray-code counter. One code per rising edge.
//              Used for the FIFO write and read pointers. Positional port
//              order (reset, clock, out) is relied on by the FIFO.
//  Ports     : reset in  1  synchronous active-high clear to zero
//              clock in  1  counting clock (rising edge)
//              out   out W  registered Gray count (straight from flops)
//  Revision  : 1.0  initial release
// ============================================================================
module gray_counter
  import gray_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         reset,
  input  logic         clock,
  output logic [W-1:0] out
);

  if (W < 2 || W > GRAY_MAX_W) begin : g_bad_width
    $error("gray_counter: W out of range");
  end

  gray_counter_core #(
    .W (W)
  ) u_core (
    .clk    (clock),
    .rst    (reset),
    .o_gray (out)
  );

endmodule : gray_counter
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module    : tb_gray_counter
//  Purpose   : Self-checking bench for gray_counter at W = 2, 4 and 8. All
//              three instances share the same clock and reset. The W=4 table
//              gives the exact code sequence. A cycle-level model covers
//              random reset traffic.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_gray_counter;

  logic       clock;
  logic       reset;
  logic       clk_en;
  logic [1:0] out2;
  logic [3:0] out4;
  logic [7:0] out8;

  int checks = 0;
  int errors = 0;

  // Model state: plain binary count per width.
  int unsigned cnt2, cnt4, cnt8;

  gray_counter #(.W(2)) u_w2 (.reset(reset), .clock(clock), .out(out2));
  gray_counter #(.W(4)) u_w4 (.reset(reset), .clock(clock), .out(out4));
  gray_counter #(.W(8)) u_w8 (.reset(reset), .clock(clock), .out(out8));

  initial clock = 1'b0;
  always #5 if (clk_en) clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] e);
    vec_t v;
    v.rst = r;
    v.exp = e;
    return v;
  endfunction

  function automatic int unsigned to_gray(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned from_gray(input int unsigned g);
    int unsigned b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive reset, clock one edge, advance the model, sample on the falling edge.
  task automatic step(input logic r);
    reset = r;
    @(posedge clock);
    if (r) begin
      cnt2 = 0; cnt4 = 0; cnt8 = 0;
    end else begin
      cnt2 = (cnt2 + 1) % 4;
      cnt4 = (cnt4 + 1) % 16;
      cnt8 = (cnt8 + 1) % 256;
    end
    @(negedge clock);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_w2"}, 32'(out2), to_gray(cnt2));
    chk({tag, "_w4"}, 32'(out4), to_gray(cnt4));
    chk({tag, "_w8"}, 32'(out8), to_gray(cnt8));
  endtask

  initial begin
    logic [1:0] p2;
    logic [3:0] p4, h4;
    logic [7:0] p8, h8;
    logic [1:0] h2;
    logic       r;

    reset  = 1'b1;
    clk_en = 1'b1;
    cnt2 = 0; cnt4 = 0; cnt8 = 0;

    // Reset for 2 edges, a full W=4 cycle, count to 0110, reset mid-count,
    // release, then hold reset for 5 edges.
    tbl.push_back(mk(1'b1, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b0011));
    tbl.push_back(mk(1'b0, 4'b0010));
    tbl.push_back(mk(1'b0, 4'b0110));
    tbl.push_back(mk(1'b0, 4'b0111));
    tbl.push_back(mk(1'b0, 4'b0101));
    tbl.push_back(mk(1'b0, 4'b0100));
    tbl.push_back(mk(1'b0, 4'b1100));
    tbl.push_back(mk(1'b0, 4'b1101));
    tbl.push_back(mk(1'b0, 4'b1111));
    tbl.push_back(mk(1'b0, 4'b1110));
    tbl.push_back(mk(1'b0, 4'b1010));
    tbl.push_back(mk(1'b0, 4'b1011));
    tbl.push_back(mk(1'b0, 4'b1001));
    tbl.push_back(mk(1'b0, 4'b1000));
    tbl.push_back(mk(1'b0, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b0011));
    tbl.push_back(mk(1'b0, 4'b0010));
    tbl.push_back(mk(1'b0, 4'b0110));
    tbl.push_back(mk(1'b1, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b0001));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b1, 4'b0000));

    @(negedge clock);
    foreach (tbl[i]) begin
      step(tbl[i].rst);
      chk($sformatf("tbl[%0d]", i), 32'(out4), 32'(tbl[i].exp));
    end

    // Release and advance a few steps so the reset pulse test has a
    // non-zero value to protect.
    for (int i = 0; i < 3; i++) step(1'b0);
    chk_model("pre_pulse");

    // Stop the clock low and pulse reset. Reset is only sampled on an edge.
    h2 = out2; h4 = out4; h8 = out8;
    clk_en = 1'b0;
    #3 reset = 1'b1;
    #10 reset = 1'b0;
    #3;
    chk("pulse_w2", 32'(out2), 32'(h2));
    chk("pulse_w4", 32'(out4), 32'(h4));
    chk("pulse_w8", 32'(out8), 32'(h8));
    clk_en = 1'b1;
    step(1'b0);
    chk_model("post_pulse");

    // Random traffic over 3*2**8 edges with occasional resets.
    for (int i = 0; i < 768; i++) begin
      p2 = out2; p4 = out4; p8 = out8;
      r  = ($urandom_range(0, 63) == 0);
      step(r);
      chk_model($sformatf("rnd[%0d]", i));
      if (!r) begin
        chk("onebit_w2", $countones(p2 ^ out2), 1);
        chk("onebit_w4", $countones(p4 ^ out4), 1);
        chk("onebit_w8", $countones(p8 ^ out8), 1);
        chk("inc_w2", from_gray(32'(out2)), (from_gray(32'(p2)) + 1) % 4);
        chk("inc_w4", from_gray(32'(out4)), (from_gray(32'(p4)) + 1) % 16);
        chk("inc_w8", from_gray(32'(out8)), (from_gray(32'(p8)) + 1) % 256);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gray_counter
`default_nettype wire
